load_store_unit: RTL
====================

# load_store_unit

Memory-stage initiator that turns pipeline load/store requests into word-aligned transactions on the data memory port. It handles byte-lane steering, write byte enables, load byte extraction and sign/zero extension. Misaligned accesses are split into two word transactions. A one-cycle completion pulse and a busy flag tell the pipeline when to stall.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; memory address wraps modulo 2^ADDR_W.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- reqValid  in  1  pipeline request present; sampled only in IDLE
- reqStore  in  1  1 = store, 0 = load
- reqFunc3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- reqAddr  in  ADDR_W  byte address
- reqWdata  in  32  store data, low-aligned
- busy  out  1  high whenever state != IDLE
- respDone  out  1  one-cycle completion pulse
- respRdata  out  32  extended load result; valid only with respDone, otherwise 0
- respFault  out  1  valid with respDone; illegal func3 or unsupported misalignment
- memReq  out  1  transaction request
- memWrite  out  1  1 = write
- memAddr  out  ADDR_W  word-aligned address; [1:0] always 00
- memByteEn  out  4  write lane enables; 0000 for reads
- memWdata  out  32  lane-steered write data
- memReady  in  1  memory accepts or completes the current transaction; memRdata is valid the same cycle

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: if reqValid, capture all req* fields.
  - If the capture is legal, go to ACC0.
  - If the capture faults, go to DONE with fault set.
- Illegal func3 faults:
  - store with func3 in {011, 1xx}
  - load with func3 in {011, 110, 111}
- Byte offset off = addr[1:0]. Access size s = 1, 2 or 4.
  - Split is needed when off + s > 4: halfword at off 3, word at off 1, 2 or 3.
- Lane steering:
  - Write data is the store data shifted left by 8·off bits, modulo word; bytes past lane 3 go to the second word's low lanes.
  - ACC0 byte enables are ((1<<s)-1)<<off, truncated to 4 bits.
  - ACC1 enables cover the remaining bytes, starting at lane 0.
- ACC0:
  - memAddr = addr & ~3.
  - On memReady: for a load, capture the lanes of memRdata; go to ACC1 if split, otherwise DONE.
- ACC1:
  - memAddr = (addr & ~3) + 4, modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x00000000.
  - On memReady: merge the upper bytes, then go to DONE.
- DONE:
  - respDone = 1.
  - For a load: respRdata = assembled value, sign-extended for B/H or zero-extended for BU/HU.
  - For a store, or when respFault = 1: respRdata = 0.
  - Go to IDLE.
- A fault never issues memReq.
- Loads drive memWdata = 0 and memByteEn = 0000.

## Timing
- Reset: state IDLE. All outputs 0: busy, respDone, respRdata, respFault, memReq, memWrite, memAddr, memByteEn, memWdata.
- Reset mid-transaction abandons the access. memReq is low in the cycle after the reset edge, and no respDone is produced.
- memReq, memWrite, memAddr, memByteEn and memWdata are registered. They stay stable from ACC entry until the cycle memReady is sampled high. memReady is ignored while memReq = 0.
- Only one transaction is outstanding at a time.
- Latency from the accept edge to respDone, with memReady tied high:
  - aligned: 2 cycles
  - split: 3 cycles
  - fault: 1 cycle
- Each memReady wait cycle adds 1 cycle.
- Pipeline handshake:
  - The pipeline holds req* stable while busy, and advances on respDone.
  - reqValid in the cycle after respDone (state IDLE) is a new request.

## Configuration
- LSU_MISALIGNED_SPLIT_EN defined: split behaviour as described above.
- LSU_MISALIGNED_SPLIT_EN undefined:
  - Any access with off + s > 4 goes IDLE → DONE with respFault = 1 and no memory transaction.
  - ACC1 and its datapath are not compiled.

## Test plan
- Aligned SW: addr 0x100, data 0xDEADBEEF, memReady high → ACC0 drives addr 0x100, byteEn 1111, wdata 0xDEADBEEF; respDone 2 cycles after accept, respFault 0.
- SB at off 2: addr 0x103E, data 0x000000A5 → memAddr 0x103C, byteEn 0100, wdata 0x00A50000.
- LB/LBU: addr 0x201, memRdata 0x00008000 → LB returns 0xFFFFFF80; LBU at the same addr returns 0x00000080.
- Split LW with macro defined: addr 0x0FFE; word 0x0FFC reads 0x2211xxxx, word 0x1000 reads 0xxxxx4433 → two transactions, respRdata 0x44332211, respDone 3 cycles after accept. Without the macro → respFault 1, memReq never asserted.
- Wrap and stall: SH at 0xFFFFFFFF, data 0xBBAA, memReady held low 2 cycles in ACC0 → ACC0 addr 0xFFFFFFFC, byteEn 1000, wdata 0xAA000000, held stable; then ACC1 addr 0x00000000, byteEn 0001, wdata 0x000000BB.
- Illegal func3 and reset: load func3 111 → respDone with fault after 1 cycle, no memReq. reset asserted during ACC0 → all outputs 0 next cycle, no respDone.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data memory port between the load/store unit and memory
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              memReq;
    logic              memWrite;
    logic [ADDR_W-1:0] memAddr;
    logic [3:0]        memByteEn;
    logic [31:0]       memWdata;
    logic              memReady;
    logic [31:0]       memRdata;

    modport master (
        output memReq, memWrite, memAddr, memByteEn, memWdata,
        input  memReady, memRdata
    );

    modport slave (
        input  memReq, memWrite, memAddr, memByteEn, memWdata,
        output memReady, memRdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store initiator; LSU_MISALIGNED_SPLIT_EN enables two-word split accesses
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               reqValid,
    input  logic               reqStore,
    input  logic [2:0]         reqFunc3,
    input  logic [ADDR_W-1:0]  reqAddr,
    input  logic [31:0]        reqWdata,
    output logic               busy,
    output logic               respDone,
    output logic [31:0]        respRdata,
    output logic               respFault,
    load_store_unit_if.master  mem
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state;
    logic        store_r;
    logic [2:0]  func3_r;
    logic [1:0]  off_r;

    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic        spans;
    logic        illegal;
    logic        fault_now;
    logic [31:0] word0;
    logic [31:0] raw_word;
    logic [31:0] load_result;
    logic        more;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic        split_r;
    logic [3:0]  be1_r;
    logic [31:0] wdata1_r;
    logic [31:0] rdata0_r;
    logic [63:0] wide_data;
`endif

    // Sign- or zero-extend the byte/halfword sitting in the low lanes of raw
    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // Decode the incoming request: lane mask over two words, legality, steered write data
    always_comb begin
        size_mask = 4'b1111;
        case (reqFunc3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask = {4'b0000, size_mask} << reqAddr[1:0];
        spans     = |lane_mask[7:4];
        illegal   = reqStore ? (reqFunc3[2] | (&reqFunc3[1:0]))
                             : ((&reqFunc3[1:0]) | (reqFunc3 == 3'b110));
`ifdef LSU_MISALIGNED_SPLIT_EN
        wide_data = {32'd0, reqWdata} << {reqAddr[1:0], 3'b000};
        word0     = wide_data[31:0];
        fault_now = illegal;
`else
        word0     = reqWdata << {reqAddr[1:0], 3'b000};
        fault_now = illegal | spans;
`endif
    end

    // Assemble the load result from the current read word (and the held first word when split)
    always_comb begin
        raw_word = mem.memRdata >> {off_r, 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (state == ACC1) begin
            raw_word = 32'({mem.memRdata, rdata0_r} >> {off_r, 3'b000});
        end
        more = split_r;
`else
        more = 1'b0;
`endif
        load_result = store_r ? 32'd0 : extend_load(raw_word, func3_r);
    end

    // Access sequencer with registered memory-port and response outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            store_r        <= 1'b0;
            func3_r        <= 3'd0;
            off_r          <= 2'd0;
            respDone       <= 1'b0;
            respRdata      <= 32'd0;
            respFault      <= 1'b0;
            mem.memReq     <= 1'b0;
            mem.memWrite   <= 1'b0;
            mem.memAddr    <= '0;
            mem.memByteEn  <= 4'd0;
            mem.memWdata   <= 32'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_r        <= 1'b0;
            be1_r          <= 4'd0;
            wdata1_r       <= 32'd0;
            rdata0_r       <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        store_r <= reqStore;
                        func3_r <= reqFunc3;
                        off_r   <= reqAddr[1:0];
                        if (fault_now) begin
                            state     <= DONE;
                            respDone  <= 1'b1;
                            respFault <= 1'b1;
                            respRdata <= 32'd0;
                        end else begin
                            state         <= ACC0;
                            mem.memReq    <= 1'b1;
                            mem.memWrite  <= reqStore;
                            mem.memAddr   <= {reqAddr[ADDR_W-1:2], 2'b00};
                            mem.memByteEn <= reqStore ? lane_mask[3:0] : 4'b0000;
                            mem.memWdata  <= reqStore ? word0 : 32'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                            split_r  <= spans;
                            be1_r    <= reqStore ? lane_mask[7:4] : 4'b0000;
                            wdata1_r <= reqStore ? wide_data[63:32] : 32'd0;
`endif
                        end
                    end
                end
                ACC0: begin
                    if (mem.memReady) begin
                        if (more) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                            state         <= ACC1;
                            mem.memAddr   <= mem.memAddr + ADDR_W'(4);
                            mem.memByteEn <= be1_r;
                            mem.memWdata  <= wdata1_r;
                            rdata0_r      <= mem.memRdata;
`endif
                        end else begin
                            state         <= DONE;
                            mem.memReq    <= 1'b0;
                            mem.memWrite  <= 1'b0;
                            mem.memAddr   <= '0;
                            mem.memByteEn <= 4'd0;
                            mem.memWdata  <= 32'd0;
                            respDone      <= 1'b1;
                            respRdata     <= load_result;
                        end
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                ACC1: begin
                    if (mem.memReady) begin
                        state         <= DONE;
                        mem.memReq    <= 1'b0;
                        mem.memWrite  <= 1'b0;
                        mem.memAddr   <= '0;
                        mem.memByteEn <= 4'd0;
                        mem.memWdata  <= 32'd0;
                        respDone      <= 1'b1;
                        respRdata     <= load_result;
                    end
                end
`endif
                DONE: begin
                    state     <= IDLE;
                    respDone  <= 1'b0;
                    respRdata <= 32'd0;
                    respFault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
